// File: rtl/storage_arb_pkg.sv
// rtl/storage_arb_pkg.sv - shared types and constants for the storage port arbiter
package storage_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } arb_state_t;

  localparam logic GNT_MGMT = 1'b0;
  localparam logic GNT_HK   = 1'b1;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;

endpackage

// File: rtl/storage_arb_prio.sv
// rtl/storage_arb_prio.sv - fixed-priority arbiter with housekeeping starvation guard
module storage_arb_prio
  import storage_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic m_req_i,
  input  logic h_req_i,
  input  logic eval_i,
  output logic grant_o,
  output logic valid_o
);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  // Grant decision: management first unless housekeeping has waited MAX_WAIT grants
  always_comb begin
    valid_o = eval_i & (m_req_i | h_req_i);
    if (h_req_i && (!m_req_i || (starve_q == 4'(MAX_WAIT)))) begin
      grant_o = GNT_HK;
    end else begin
      grant_o = GNT_MGMT;
    end
  end

  // Starvation counter next state; only moves on an arbitration slot
  always_comb begin
    starve_d = starve_q;
    if (eval_i) begin
      if (!h_req_i || (grant_o == GNT_HK)) begin
        starve_d = 4'd0;
      end else if (starve_q != 4'(MAX_WAIT)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/storage_port_arbiter.sv
// rtl/storage_port_arbiter.sv - shares one single-port SRAM between mgmt core and housekeeping SPI
module storage_port_arbiter
  import storage_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic                core_clk,
  input  logic                core_rst,
  input  logic                m_req,
  input  logic                m_we,
  input  logic [DW/8-1:0]     m_wmask,
  input  logic [AW-1:0]       m_addr,
  input  logic [DW-1:0]       m_wdata,
  output logic                m_ack,
  output logic [DW-1:0]       m_rdata,
  input  logic                h_req,
  input  logic [AW-1:0]       h_addr,
  output logic                h_ack,
  output logic [DW-1:0]       h_rdata,
  output logic                ram_ena,
  output logic                ram_wen,
  output logic [DW/8-1:0]     ram_wen_mask,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_wdata,
  input  logic [DW-1:0]       ram_rdata,
  output logic                busy
);

  localparam int MW = DW / 8;

  arb_state_t      state_q;
  logic            gnt_q;
  logic            we_q;
  logic            m_ack_q;
  logic            h_ack_q;
  logic [DW-1:0]   m_rdata_q;
  logic [DW-1:0]   h_rdata_q;
  logic            ram_ena_q;
  logic            ram_wen_q;
  logic [MW-1:0]   ram_mask_q;
  logic [AW-1:0]   ram_addr_q;
  logic [DW-1:0]   ram_wdata_q;
  logic            busy_q;

  logic            arb_grant;
  logic            arb_valid;

  storage_arb_prio #(
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .clk_i   (core_clk),
    .rst_i   (core_rst),
    .m_req_i (m_req),
    .h_req_i (h_req),
    .eval_i  (state_q == IDLE),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  // Access sequencer: latch winner in IDLE, one-cycle SRAM enable, capture, then ack
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_MGMT;
      we_q        <= 1'b0;
      m_ack_q     <= 1'b0;
      h_ack_q     <= 1'b0;
      m_rdata_q   <= '0;
      h_rdata_q   <= '0;
      ram_ena_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_mask_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gnt_q     <= arb_grant;
            state_q   <= ISSUE;
            busy_q    <= 1'b1;
            ram_ena_q <= 1'b1;
            if (arb_grant == GNT_HK) begin
              // Housekeeping is read-only: never carry a write into the SRAM
              we_q        <= 1'b0;
              ram_wen_q   <= 1'b0;
              ram_mask_q  <= '0;
              ram_addr_q  <= h_addr;
              ram_wdata_q <= '0;
            end else begin
              we_q        <= m_we;
              ram_wen_q   <= m_we;
              ram_mask_q  <= m_wmask;
              ram_addr_q  <= m_addr;
              ram_wdata_q <= m_wdata;
            end
          end
        end
        ISSUE: begin
          ram_ena_q   <= 1'b0;
          ram_wen_q   <= 1'b0;
          ram_mask_q  <= '0;
          ram_addr_q  <= '0;
          ram_wdata_q <= '0;
          state_q     <= CAPTURE;
        end
        CAPTURE: begin
          // Read data appears the cycle after the enable edge; writes keep old rdata
          if (!we_q) begin
            if (gnt_q == GNT_HK) begin
              h_rdata_q <= ram_rdata;
            end else begin
              m_rdata_q <= ram_rdata;
            end
          end
          m_ack_q <= (gnt_q == GNT_MGMT);
          h_ack_q <= (gnt_q == GNT_HK);
          state_q <= ACK;
        end
        ACK: begin
          m_ack_q <= 1'b0;
          h_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_ack        = m_ack_q;
  assign h_ack        = h_ack_q;
  assign m_rdata      = m_rdata_q;
  assign h_rdata      = h_rdata_q;
  assign ram_ena      = ram_ena_q;
  assign ram_wen      = ram_wen_q;
  assign ram_wen_mask = ram_mask_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign busy         = busy_q;

endmodule
